// File: rtl/fx_delay_ctrl_if.sv
// Delay-line RAM bus between the FX 6 sequencer (master) and the shared single-port RAM (slave).
// A read completes in the cycle mem_ack is high, with mem_rdata valid in that same cycle.
interface fx_delay_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W:0]   mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/fx_delay_ctrl.sv
// FX 6 delay-line sequencer: per sample, read and then write the L tap, then the R tap, on one RAM.
// Define FX_DELAY_TIME_SLEW_EN to slew dly_len by at most one step per accepted sample.
module fx_delay_ctrl #(
    parameter int DATA_W  = 16,
    parameter int PARAM_W = 8,
    parameter int ADDR_W  = 12
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sample_en,
    input  logic [1:0][DATA_W-1:0] wr_data,
    input  logic [PARAM_W-1:0]     fx_time,
    output logic [1:0][DATA_W-1:0] tap_out,
    output logic                   tap_valid,
    output logic                   busy,
    output logic                   overrun,
    fx_delay_ctrl_if.master        mem
);
    typedef enum logic [2:0] {IDLE, RD_L, WR_L, RD_R, WR_R, DONE} state_e;

    state_e                  state_q;
    logic [ADDR_W-1:0]       wr_ptr_q, fill_cnt_q, dly_len_q;
    logic [ADDR_W-1:0]       dly_shift, dly_tgt, dly_len_d;
    logic [ADDR_W-1:0]       rd_ptr, rd_ptr_new;
    logic                    tap_mask;
    logic [1:0][DATA_W-1:0]  wdat_q, tap_q, tap_out_q;
    logic                    tap_valid_q, busy_q, overrun_q;
    logic                    mem_req_q, mem_we_q;
    logic [ADDR_W:0]         mem_addr_q;
    logic [DATA_W-1:0]       mem_wdata_q;

    always_comb begin
        dly_shift = ADDR_W'(fx_time) << (ADDR_W - PARAM_W);
        dly_tgt   = (dly_shift == '0) ? ADDR_W'(1) : dly_shift;
`ifdef FX_DELAY_TIME_SLEW_EN
        dly_len_d = dly_len_q;
        if (dly_tgt > dly_len_q)      dly_len_d = dly_len_q + ADDR_W'(1);
        else if (dly_tgt < dly_len_q) dly_len_d = dly_len_q - ADDR_W'(1);
`else
        dly_len_d = dly_tgt;
`endif
    end

    // Taps pointing past what has been written since reset read back as silence.
    assign rd_ptr_new = wr_ptr_q - dly_len_d;
    assign rd_ptr     = wr_ptr_q - dly_len_q;
    assign tap_mask   = fill_cnt_q < dly_len_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            fill_cnt_q  <= '0;
            dly_len_q   <= ADDR_W'(1);
            wdat_q      <= '0;
            tap_q       <= '0;
            tap_out_q   <= '0;
            tap_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            tap_valid_q <= 1'b0;
            if (sample_en && state_q != IDLE) overrun_q <= 1'b1;
            unique case (state_q)
                IDLE: if (sample_en) begin
                    wdat_q     <= wr_data;
                    dly_len_q  <= dly_len_d;
                    mem_req_q  <= 1'b1;
                    mem_we_q   <= 1'b0;
                    mem_addr_q <= {1'b0, rd_ptr_new};
                    busy_q     <= 1'b1;
                    state_q    <= RD_L;
                end
                RD_L: if (mem.mem_ack) begin
                    tap_q[0]    <= tap_mask ? '0 : mem.mem_rdata;
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= {1'b0, wr_ptr_q};
                    mem_wdata_q <= wdat_q[0];
                    state_q     <= WR_L;
                end
                WR_L: if (mem.mem_ack) begin
                    mem_we_q   <= 1'b0;
                    mem_addr_q <= {1'b1, rd_ptr};
                    state_q    <= RD_R;
                end
                RD_R: if (mem.mem_ack) begin
                    tap_q[1]    <= tap_mask ? '0 : mem.mem_rdata;
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= {1'b1, wr_ptr_q};
                    mem_wdata_q <= wdat_q[1];
                    state_q     <= WR_R;
                end
                WR_R: if (mem.mem_ack) begin
                    mem_req_q   <= 1'b0;
                    mem_we_q    <= 1'b0;
                    tap_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    tap_out_q <= tap_q;
                    wr_ptr_q  <= wr_ptr_q + ADDR_W'(1);
                    if (fill_cnt_q != '1) fill_cnt_q <= fill_cnt_q + ADDR_W'(1);
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tap_out       = tap_out_q;
    assign tap_valid     = tap_valid_q;
    assign busy          = busy_q;
    assign overrun       = overrun_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
endmodule
